operand_fetch: RTL and testbench
================================

# operand_fetch

Register-read stage of the five-stage MIPS pipeline. It sits between instruction decode and execute and owns the architectural register file. It reads source operands for each issued instruction and accepts register writes from the write-back stage. A 32-bit pending-write scoreboard holds instructions in this stage until their operands are safe to read.

## Interface
Parameters:
- `WIDTH`, 32: data width of registers and operands.
- `NREG`, 32: number of registers; 5-bit addresses.

Ports:
- `clk`, input, 1: single clock; all state updates on the rising edge.
- `reset`, input, 1: asynchronous, active-low.
- `in_valid`, input, 1: decode presents an instruction.
- `in_ready`, output, 1: stage accepts the instruction this cycle.
- `opcode`, input, 6: 1=addu, 2=beq, 3=lw, 4=mult, 5=addi, 6=j, 7=nop, 8=call; any other value is treated as nop.
- `src`, `dest`, `target`, input, 5 each: register fields.
- `imm`, input, 16: immediate field.
- `wb_we`, input, 1: write-back write enable.
- `wb_addr`, input, 5: write-back register address.
- `wb_data`, input, 32: write-back data.
- `out_valid`, output, 1: execute-side instruction valid.
- `out_ready`, input, 1: execute accepts.
- `out_opcode`, output, 6: registered opcode.
- `out_dest`, `out_target`, output, 5 each: registered register fields.
- `out_a`, `out_b`, output, 32 each: operand values.
- `out_imm`, output, 32: sign-extended `imm`.
- `stall`, output, 1: a hazard is blocking issue (debug/perf).

## Operation
- Register file reset contents: every register is 0 except r4=3, r29=0x51, r30=150, r31=190. r0 is an ordinary writable register.
- Operand selection by opcode:
  - addu, mult, beq: A=reg[src], B=reg[dest].
  - lw, addi: A=reg[src], B=0.
  - j, nop, call, and any other opcode: A=0, B=0.
- Write register by opcode:
  - addu, mult: `target`.
  - lw, addi: `dest`.
  - call: r31.
  - beq, j, nop: none.
- Write port: when `wb_we`=1, reg[wb_addr] ← wb_data at the clock edge.
- Bypass: if `wb_we`=1 and `wb_addr` equals a read address in the same cycle, the operand takes `wb_data`, not the stale register value.
- Scoreboard `pend[31:0]`:
  - On issue of an instruction that writes register k, set bit k.
  - On `wb_we`, clear bit `wb_addr`.
  - If the set and the clear hit the same bit in one cycle, the set wins.
- Hazard: `stall`=1 when `in_valid`=1 and either condition holds:
  - any read register is pending and not being bypassed this cycle.
  - the write register is pending and not being cleared this cycle (WAW).
- `in_ready` = !stall && (!out_valid || out_ready).
- Issue occurs when `in_valid` && `in_ready`. On issue, the output register loads the opcode, fields, operands and `out_imm`, and `out_valid` ← 1.
- When `out_valid` && `out_ready` with no new issue, `out_valid` ← 0.
- When the output register is held (`out_valid`=1, `out_ready`=0), all `out_*` values stay stable.

## Timing
- Reset (asynchronous assert, synchronous release) drives:
  - `out_valid`=0, `out_opcode`=7 (nop), all other `out_*`=0.
  - `pend`=0, register file to its reset contents.
  - `stall` and `in_ready` are combinational and follow from this state.
- Reset asserted mid-operation drops any in-flight instruction and clears the scoreboard. Write-back writes in that cycle are discarded.
- Latency: one cycle from issue to `out_valid`. Back-to-back issue gives one instruction per cycle when there are no hazards.
- A write-back and a read of the same register in one cycle return the new value (zero-cycle bypass). The dependent instruction issues in the same cycle its producer writes back.
- `in_valid`=0 never asserts `stall`.

## Test plan
- Reset, then issue addu src=29 dest=30 target=5 → next cycle: out_valid=1, out_a=0x51, out_b=150, pend[5]=1.
- addu target=5 issued, then addi src=5 dest=6 presented → stall=1, in_ready=0. Assert wb_we, wb_addr=5, wb_data=0x1234 → addi issues that same cycle with out_a=0x1234.
- out_ready=0 with out_valid=1 → out_* held stable and in_ready=0 for 3 cycles. Raise out_ready → next instruction issues.
- call issued while pend[31]=0 → pend[31]=1. A second call is stalled until wb_we with wb_addr=31.
- In the same cycle, issue lw dest=7 and write back wb_addr=7 → pend[7] ends 1 (set wins).
- Assert reset mid-stall with pend=0x20 → out_valid=0, pend=0, r4=3 immediately, without waiting for a clock.

Source files
------------

// File: rtl/operand_fetch_if.sv
// Decode/execute/write-back handshake bundle for the operand_fetch register-read stage.
interface operand_fetch_if #(
    parameter int WIDTH = 32
);
    logic             in_valid;
    logic             in_ready;
    logic [5:0]       opcode;
    logic [4:0]       src;
    logic [4:0]       dest;
    logic [4:0]       target;
    logic [15:0]      imm;
    logic             wb_we;
    logic [4:0]       wb_addr;
    logic [WIDTH-1:0] wb_data;
    logic             out_valid;
    logic             out_ready;
    logic [5:0]       out_opcode;
    logic [4:0]       out_dest;
    logic [4:0]       out_target;
    logic [WIDTH-1:0] out_a;
    logic [WIDTH-1:0] out_b;
    logic [WIDTH-1:0] out_imm;
    logic             stall;

    modport slave (
        input  in_valid, opcode, src, dest, target, imm,
        input  wb_we, wb_addr, wb_data, out_ready,
        output in_ready, out_valid, out_opcode, out_dest, out_target,
        output out_a, out_b, out_imm, stall
    );

    modport master (
        output in_valid, opcode, src, dest, target, imm,
        output wb_we, wb_addr, wb_data, out_ready,
        input  in_ready, out_valid, out_opcode, out_dest, out_target,
        input  out_a, out_b, out_imm, stall
    );
endinterface

// File: rtl/operand_fetch.sv
// Register-read stage: owns the register file, bypasses same-cycle write-back,
// and holds instructions back with a pending-write scoreboard.
module operand_fetch #(
    parameter int WIDTH = 32,
    parameter int NREG  = 32
) (
    input logic            clk,
    input logic            reset,
    operand_fetch_if.slave bus
);
    localparam logic [5:0] OP_ADDU = 6'd1;
    localparam logic [5:0] OP_BEQ  = 6'd2;
    localparam logic [5:0] OP_LW   = 6'd3;
    localparam logic [5:0] OP_MULT = 6'd4;
    localparam logic [5:0] OP_ADDI = 6'd5;
    localparam logic [5:0] OP_NOP  = 6'd7;
    localparam logic [5:0] OP_CALL = 6'd8;

    logic [WIDTH-1:0] r_regs [NREG];
    logic [NREG-1:0]  r_pend;
    logic             r_out_valid;
    logic [5:0]       r_out_opcode;
    logic [4:0]       r_out_dest;
    logic [4:0]       r_out_target;
    logic [WIDTH-1:0] r_out_a;
    logic [WIDTH-1:0] r_out_b;
    logic [WIDTH-1:0] r_out_imm;

    logic             w_use_a;
    logic             w_use_b;
    logic             w_wr_en;
    logic [4:0]       w_wr_addr;
    logic             w_byp_a;
    logic             w_byp_b;
    logic             w_clr_wr;
    logic             w_stall;
    logic             w_in_ready;
    logic             w_issue;
    logic [WIDTH-1:0] w_a;
    logic [WIDTH-1:0] w_b;
    logic [WIDTH-1:0] w_imm;
    logic [NREG-1:0]  w_pend_next;

    function automatic logic [WIDTH-1:0] reg_init(input int idx);
        logic [WIDTH-1:0] v;
        case (idx)
            32'sd4:  v = WIDTH'(32'd3);
            32'sd29: v = WIDTH'(32'h51);
            32'sd30: v = WIDTH'(32'd150);
            32'sd31: v = WIDTH'(32'd190);
            default: v = '0;
        endcase
        return v;
    endfunction

    // Decode which operands are read and which register the instruction writes.
    always_comb begin
        w_use_a   = 1'b0;
        w_use_b   = 1'b0;
        w_wr_en   = 1'b0;
        w_wr_addr = 5'd0;
        case (bus.opcode)
            OP_ADDU, OP_MULT: begin
                w_use_a   = 1'b1;
                w_use_b   = 1'b1;
                w_wr_en   = 1'b1;
                w_wr_addr = bus.target;
            end
            OP_BEQ: begin
                w_use_a = 1'b1;
                w_use_b = 1'b1;
            end
            OP_LW, OP_ADDI: begin
                w_use_a   = 1'b1;
                w_wr_en   = 1'b1;
                w_wr_addr = bus.dest;
            end
            OP_CALL: begin
                w_wr_en   = 1'b1;
                w_wr_addr = 5'd31;
            end
            default: begin
                w_wr_en = 1'b0;
            end
        endcase
    end

    // Operand read with zero-cycle write-back bypass, plus hazard detection.
    always_comb begin
        w_byp_a  = bus.wb_we && (bus.wb_addr == bus.src);
        w_byp_b  = bus.wb_we && (bus.wb_addr == bus.dest);
        w_clr_wr = bus.wb_we && (bus.wb_addr == w_wr_addr);

        if (!w_use_a) begin
            w_a = '0;
        end else if (w_byp_a) begin
            w_a = bus.wb_data;
        end else begin
            w_a = r_regs[bus.src];
        end

        if (!w_use_b) begin
            w_b = '0;
        end else if (w_byp_b) begin
            w_b = bus.wb_data;
        end else begin
            w_b = r_regs[bus.dest];
        end

        // A pending source is fine only when its producer is writing back right now.
        w_stall = bus.in_valid &&
                  ((w_use_a && r_pend[bus.src]  && !w_byp_a) ||
                   (w_use_b && r_pend[bus.dest] && !w_byp_b) ||
                   (w_wr_en && r_pend[w_wr_addr] && !w_clr_wr));
        w_in_ready = !w_stall && (!r_out_valid || bus.out_ready);
        w_issue    = bus.in_valid && w_in_ready;
        w_imm      = {{(WIDTH-16){bus.imm[15]}}, bus.imm};
    end

    // Scoreboard next state: clear on write-back, then set on issue so the set wins.
    always_comb begin
        w_pend_next = r_pend;
        if (bus.wb_we) begin
            w_pend_next[bus.wb_addr] = 1'b0;
        end else begin
            w_pend_next = r_pend;
        end
        if (w_issue && w_wr_en) begin
            w_pend_next[w_wr_addr] = 1'b1;
        end else begin
            w_pend_next = w_pend_next;
        end
    end

    // Register file and scoreboard state.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_pend <= '0;
            for (int i = 0; i < NREG; i++) begin
                r_regs[i] <= reg_init(i);
            end
        end else begin
            r_pend <= w_pend_next;
            if (bus.wb_we) begin
                r_regs[bus.wb_addr] <= bus.wb_data;
            end
        end
    end

    // Output pipeline register toward execute; holds while execute is not ready.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_out_valid  <= 1'b0;
            r_out_opcode <= OP_NOP;
            r_out_dest   <= 5'd0;
            r_out_target <= 5'd0;
            r_out_a      <= '0;
            r_out_b      <= '0;
            r_out_imm    <= '0;
        end else if (w_issue) begin
            r_out_valid  <= 1'b1;
            r_out_opcode <= bus.opcode;
            r_out_dest   <= bus.dest;
            r_out_target <= bus.target;
            r_out_a      <= w_a;
            r_out_b      <= w_b;
            r_out_imm    <= w_imm;
        end else if (bus.out_ready) begin
            r_out_valid <= 1'b0;
        end
    end

    assign bus.in_ready   = w_in_ready;
    assign bus.stall      = w_stall;
    assign bus.out_valid  = r_out_valid;
    assign bus.out_opcode = r_out_opcode;
    assign bus.out_dest   = r_out_dest;
    assign bus.out_target = r_out_target;
    assign bus.out_a      = r_out_a;
    assign bus.out_b      = r_out_b;
    assign bus.out_imm    = r_out_imm;
endmodule

// File: tb/tb_operand_fetch.sv
// Directed bench for operand_fetch: a vector table for single-cycle behaviour
// and hand-written sequences for backpressure, scoreboard and reset corners.
module tb_operand_fetch;
    logic clk;
    logic reset;
    int   n_total;
    int   n_pass;

    operand_fetch_if #(.WIDTH(32)) bus ();

    operand_fetch #(.WIDTH(32), .NREG(32)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        iv;
        logic [5:0]  op;
        logic [4:0]  src;
        logic [4:0]  dst;
        logic [4:0]  tgt;
        logic [15:0] imm;
        logic        we;
        logic [4:0]  wa;
        logic [31:0] wd;
        logic        stall;
        logic        valid;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] im;
    } vec_t;

    localparam int NV = 15;
    vec_t v [NV];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act !== exp) begin
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end else begin
            n_pass++;
        end
    endtask

    task automatic drive(input logic iv, input logic [5:0] op, input logic [4:0] s,
                         input logic [4:0] d, input logic [4:0] t, input logic [15:0] im,
                         input logic we, input logic [4:0] wa, input logic [31:0] wd);
        bus.in_valid = iv;
        bus.opcode   = op;
        bus.src      = s;
        bus.dest     = d;
        bus.target   = t;
        bus.imm      = im;
        bus.wb_we    = we;
        bus.wb_addr  = wa;
        bus.wb_data  = wd;
    endtask

    task automatic idle();
        drive(1'b0, 6'd7, 5'd0, 5'd0, 5'd0, 16'd0, 1'b0, 5'd0, 32'd0);
    endtask

    initial begin
        n_total = 0;
        n_pass  = 0;
        reset   = 1'b0;
        bus.out_ready = 1'b1;
        idle();

        //            iv    op     src    dst    tgt    imm        we    wa     wd             stall valid a              b             im
        v[0]  = '{1'b1, 6'd1, 5'd29, 5'd30, 5'd5,  16'h0001, 1'b0, 5'd0, 32'd0,         1'b0, 1'b1, 32'h51,        32'd150,      32'h1};
        v[1]  = '{1'b1, 6'd2, 5'd4,  5'd31, 5'd0,  16'hFFFF, 1'b0, 5'd0, 32'd0,         1'b0, 1'b1, 32'd3,         32'd190,      32'hFFFFFFFF};
        v[2]  = '{1'b1, 6'd3, 5'd30, 5'd7,  5'd0,  16'h8000, 1'b0, 5'd0, 32'd0,         1'b0, 1'b1, 32'd150,       32'd0,        32'hFFFF8000};
        v[3]  = '{1'b1, 6'd5, 5'd29, 5'd8,  5'd0,  16'h7FFF, 1'b0, 5'd0, 32'd0,         1'b0, 1'b1, 32'h51,        32'd0,        32'h00007FFF};
        v[4]  = '{1'b1, 6'd6, 5'd4,  5'd30, 5'd0,  16'h0000, 1'b0, 5'd0, 32'd0,         1'b0, 1'b1, 32'd0,         32'd0,        32'h0};
        v[5]  = '{1'b1, 6'd9, 5'd29, 5'd30, 5'd0,  16'h0010, 1'b0, 5'd0, 32'd0,         1'b0, 1'b1, 32'd0,         32'd0,        32'h10};
        v[6]  = '{1'b1, 6'd4, 5'd4,  5'd29, 5'd9,  16'h0000, 1'b1, 5'd4, 32'hDEAD,      1'b0, 1'b1, 32'hDEAD,      32'h51,       32'h0};
        v[7]  = '{1'b1, 6'd1, 5'd4,  5'd4,  5'd10, 16'h0000, 1'b0, 5'd0, 32'd0,         1'b0, 1'b1, 32'hDEAD,      32'hDEAD,     32'h0};
        v[8]  = '{1'b1, 6'd1, 5'd5,  5'd0,  5'd11, 16'h0000, 1'b1, 5'd5, 32'h1234,      1'b0, 1'b1, 32'h1234,      32'd0,        32'h0};
        v[9]  = '{1'b1, 6'd7, 5'd5,  5'd5,  5'd0,  16'h0000, 1'b0, 5'd0, 32'd0,         1'b0, 1'b1, 32'd0,         32'd0,        32'h0};
        v[10] = '{1'b1, 6'd5, 5'd7,  5'd12, 5'd0,  16'h0002, 1'b0, 5'd0, 32'd0,         1'b1, 1'b0, 32'd0,         32'd0,        32'h0};
        v[11] = '{1'b1, 6'd5, 5'd7,  5'd12, 5'd0,  16'h0002, 1'b1, 5'd7, 32'h77,        1'b0, 1'b1, 32'h77,        32'd0,        32'h2};
        v[12] = '{1'b0, 6'd5, 5'd8,  5'd13, 5'd0,  16'h0000, 1'b0, 5'd0, 32'd0,         1'b0, 1'b0, 32'd0,         32'd0,        32'h0};
        v[13] = '{1'b1, 6'd3, 5'd0,  5'd9,  5'd0,  16'h0000, 1'b0, 5'd0, 32'd0,         1'b1, 1'b0, 32'd0,         32'd0,        32'h0};
        v[14] = '{1'b1, 6'd3, 5'd0,  5'd9,  5'd0,  16'h0004, 1'b1, 5'd9, 32'h5,         1'b0, 1'b1, 32'd0,         32'd0,        32'h4};

        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        #1;
        chk("rst out_valid",  32'(bus.out_valid),  32'd0);
        chk("rst out_opcode", 32'(bus.out_opcode), 32'd7);
        chk("rst out_a",      bus.out_a,           32'd0);
        chk("rst out_imm",    bus.out_imm,         32'd0);
        chk("rst pend",       dut.r_pend,          32'd0);
        chk("rst r4",         dut.r_regs[4],       32'd3);
        chk("rst r31",        dut.r_regs[31],      32'd190);
        chk("rst in_ready",   32'(bus.in_ready),   32'd1);
        chk("rst stall",      32'(bus.stall),      32'd0);

        for (int i = 0; i < NV; i++) begin
            @(negedge clk);
            drive(v[i].iv, v[i].op, v[i].src, v[i].dst, v[i].tgt, v[i].imm, v[i].we, v[i].wa, v[i].wd);
            #1;
            chk($sformatf("v%0d stall", i),    32'(bus.stall),    32'(v[i].stall));
            chk($sformatf("v%0d in_ready", i), 32'(bus.in_ready), 32'(!v[i].stall));
            @(posedge clk);
            #1;
            chk($sformatf("v%0d out_valid", i), 32'(bus.out_valid), 32'(v[i].valid));
            if (v[i].valid) begin
                chk($sformatf("v%0d out_a", i),      bus.out_a,           v[i].a);
                chk($sformatf("v%0d out_b", i),      bus.out_b,           v[i].b);
                chk($sformatf("v%0d out_imm", i),    bus.out_imm,         v[i].im);
                chk($sformatf("v%0d out_opcode", i), 32'(bus.out_opcode), 32'(v[i].op));
            end
        end
        @(negedge clk);
        idle();
        #1;
        chk("tbl pend", dut.r_pend,     32'h00001F00);
        chk("tbl r7",   dut.r_regs[7],  32'h77);
        chk("tbl r9",   dut.r_regs[9],  32'h5);

        // fresh state for the multi-cycle sequences
        reset = 1'b0;
        @(posedge clk);
        @(negedge clk);
        reset = 1'b1;

        // backpressure: output holds for three cycles, then next instruction issues
        drive(1'b1, 6'd5, 5'd29, 5'd6, 5'd0, 16'd3, 1'b0, 5'd0, 32'd0);
        @(posedge clk);
        #1;
        chk("bp first valid", 32'(bus.out_valid), 32'd1);
        chk("bp first a",     bus.out_a,          32'h51);
        @(negedge clk);
        bus.out_ready = 1'b0;
        drive(1'b1, 6'd6, 5'd0, 5'd0, 5'd0, 16'd0, 1'b0, 5'd0, 32'd0);
        for (int c = 0; c < 3; c++) begin
            #1;
            chk($sformatf("bp%0d in_ready", c), 32'(bus.in_ready), 32'd0);
            @(posedge clk);
            #1;
            chk($sformatf("bp%0d valid", c),  32'(bus.out_valid),  32'd1);
            chk($sformatf("bp%0d a", c),      bus.out_a,           32'h51);
            chk($sformatf("bp%0d imm", c),    bus.out_imm,         32'd3);
            chk($sformatf("bp%0d opcode", c), 32'(bus.out_opcode), 32'd5);
            @(negedge clk);
        end
        bus.out_ready = 1'b1;
        #1;
        chk("bp release in_ready", 32'(bus.in_ready), 32'd1);
        @(posedge clk);
        #1;
        chk("bp release opcode", 32'(bus.out_opcode), 32'd6);
        chk("bp release a",      bus.out_a,           32'd0);

        // call sets pend[31]; a second call waits for write-back of r31
        @(negedge clk);
        drive(1'b1, 6'd8, 5'd0, 5'd0, 5'd0, 16'd0, 1'b0, 5'd0, 32'd0);
        @(posedge clk);
        #1;
        chk("call pend31", 32'(dut.r_pend[31]), 32'd1);
        @(negedge clk);
        for (int c = 0; c < 2; c++) begin
            #1;
            chk($sformatf("call2 stall%0d", c), 32'(bus.stall), 32'd1);
            @(posedge clk);
            @(negedge clk);
        end
        drive(1'b1, 6'd8, 5'd0, 5'd0, 5'd0, 16'd0, 1'b1, 5'd31, 32'h99);
        #1;
        chk("call2 wb stall", 32'(bus.stall), 32'd0);
        @(posedge clk);
        #1;
        chk("call2 opcode", 32'(bus.out_opcode), 32'd8);
        chk("call2 valid",  32'(bus.out_valid),  32'd1);
        chk("call2 pend31", 32'(dut.r_pend[31]), 32'd1);
        chk("call2 r31",    dut.r_regs[31],      32'h99);

        // issue lw dest=7 and write back r7 in the same cycle: set wins
        @(negedge clk);
        drive(1'b1, 6'd3, 5'd0, 5'd7, 5'd0, 16'd0, 1'b1, 5'd7, 32'h70);
        #1;
        chk("setwin stall", 32'(bus.stall), 32'd0);
        @(posedge clk);
        #1;
        chk("setwin pend7", 32'(dut.r_pend[7]), 32'd1);

        // async reset in the middle of a stall
        @(negedge clk);
        reset = 1'b0;
        idle();
        @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        drive(1'b0, 6'd7, 5'd0, 5'd0, 5'd0, 16'd0, 1'b1, 5'd4, 32'h44);
        @(posedge clk);
        @(negedge clk);
        drive(1'b1, 6'd1, 5'd29, 5'd30, 5'd5, 16'd0, 1'b0, 5'd0, 32'd0);
        @(posedge clk);
        @(negedge clk);
        drive(1'b1, 6'd5, 5'd5, 5'd6, 5'd0, 16'd0, 1'b0, 5'd0, 32'd0);
        #1;
        chk("mid pend",  dut.r_pend,        32'h20);
        chk("mid r4",    dut.r_regs[4],     32'h44);
        chk("mid stall", 32'(bus.stall),    32'd1);
        chk("mid ready", 32'(bus.in_ready), 32'd0);
        #2;
        reset = 1'b0;
        #1;
        chk("arst out_valid",  32'(bus.out_valid),  32'd0);
        chk("arst out_opcode", 32'(bus.out_opcode), 32'd7);
        chk("arst pend",       dut.r_pend,          32'd0);
        chk("arst r4",         dut.r_regs[4],       32'd3);
        chk("arst stall",      32'(bus.stall),      32'd0);
        @(negedge clk);
        reset = 1'b1;
        idle();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
